// File: rtl/mem_dump_tx.sv
// Reads a block of 32-bit words from memory and streams them out as 8N1 UART bytes,
// little-endian, keeping a running XOR that can be appended as a trailer byte.
module mem_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 23,
  parameter bit          SEND_XOR     = 1'b1
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        xorc
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StTrailer, StFinish} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [31:0]       r_word;
  logic [1:0]        r_byte_idx;
  logic [3:0]        r_bit_idx;
  logic [CntW-1:0]   r_clk_cnt;
  logic [7:0]        r_xorc;

  logic       w_in_frame;
  logic       w_bit_end;
  logic       w_frame_end;
  logic       w_frame_first;
  logic [7:0] w_frame_byte;
  logic [2:0] w_bit_sel;

  assign w_in_frame    = (r_state == StSend) || (r_state == StTrailer);
  assign w_bit_end     = w_in_frame && (r_clk_cnt == CntW'(CLKS_PER_BIT - 1));
  assign w_frame_end   = w_bit_end && (r_bit_idx == 4'd9);
  assign w_frame_first = (r_bit_idx == 4'd0) && (r_clk_cnt == '0);
  assign w_frame_byte  = (r_state == StTrailer) ? r_xorc : r_word[{r_byte_idx, 3'b000} +: 8];
  assign w_bit_sel     = 3'(r_bit_idx - 4'd1);

  // State register
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = (word_count == '0) ? StFinish : StFetch;
        end
      end
      StFetch: begin
        if (mem_valid) begin
          w_state_next = StSend;
        end
      end
      StSend: begin
        if (w_frame_end && (r_byte_idx == 2'd3)) begin
          if (r_remaining != ADDR_W'(1)) begin
            w_state_next = StFetch;
          end else begin
            w_state_next = SEND_XOR ? StTrailer : StFinish;
          end
        end
      end
      StTrailer: begin
        if (w_frame_end) begin
          w_state_next = StFinish;
        end
      end
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Datapath: address/count, word buffer, bit timing and running XOR
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_bit_idx   <= '0;
      r_clk_cnt   <= '0;
      r_xorc      <= '0;
    end else begin
      if ((r_state == StIdle) && start) begin
        r_addr      <= base_addr;
        r_remaining <= word_count;
        r_xorc      <= '0;
      end
      if ((r_state == StFetch) && mem_valid) begin
        r_word     <= mem_data;
        r_byte_idx <= '0;
        r_bit_idx  <= '0;
        r_clk_cnt  <= '0;
      end
      if (w_in_frame) begin
        // Fold each data byte in as its start bit begins; the trailer is not folded.
        if ((r_state == StSend) && w_frame_first) begin
          r_xorc <= r_xorc ^ w_frame_byte;
        end
        if (w_bit_end) begin
          r_clk_cnt <= '0;
          if (r_bit_idx == 4'd9) begin
            r_bit_idx <= '0;
            if (r_state == StSend) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              if (r_byte_idx == 2'd3) begin
                r_remaining <= r_remaining - ADDR_W'(1);
                r_addr      <= r_addr + ADDR_W'(1);
              end
            end
          end else begin
            r_bit_idx <= r_bit_idx + 4'd1;
          end
        end else begin
          r_clk_cnt <= r_clk_cnt + CntW'(1);
        end
      end
    end
  end

  // Outputs
  always_comb begin
    tx       = 1'b1;
    mem_rd   = (r_state == StFetch);
    done     = (r_state == StFinish);
    busy     = (r_state != StIdle);
    mem_addr = r_addr;
    xorc     = r_xorc;
    if (w_in_frame) begin
      if (r_bit_idx == 4'd0) begin
        tx = 1'b0;
      end else if (r_bit_idx <= 4'd8) begin
        tx = w_frame_byte[w_bit_sel];
      end
    end
  end

endmodule
